// File: rtl/apb_xfer_sequencer.sv
// AHB-to-APB single-transfer sequencer: OKAY response 4 cycles after the address phase, +1 per APB wait state.
// Holds AHB with h_ready_out=0 while busy, gives up after TIMEOUT ACCESS cycles and returns a two-cycle ERROR.
module apb_xfer_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              h_clk,
    input  logic              h_reset,
    input  logic              h_sel,
    input  logic              h_ready_in,
    input  logic              h_write,
    input  logic [1:0]        h_trans,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ready_out,
    output logic              h_resp,
    output logic [DATA_W-1:0] h_rdata,
    output logic              p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    input  logic              p_slverr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       valid_req;
    logic       unused_trans_lsb;

    // NONSEQ and SEQ both start a transfer; only bit 1 of h_trans matters.
    assign valid_req        = h_sel & h_ready_in & h_trans[1];
    assign unused_trans_lsb = h_trans[0];

    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            h_ready_out <= 1'b1;
            h_resp      <= 1'b0;
            h_rdata     <= '0;
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            p_write     <= 1'b0;
            p_addr      <= '0;
            p_wdata     <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR2: begin
                    h_resp <= 1'b0;
                    if (valid_req) begin
                        state       <= S_WDATA;
                        p_addr      <= h_addr;
                        p_write     <= h_write;
                        h_ready_out <= 1'b0;
                    end else begin
                        state       <= S_IDLE;
                        h_ready_out <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (p_write) begin
                        p_wdata <= h_wdata;
                    end
                    state <= S_SETUP;
                    p_sel <= 1'b1;
                end
                S_SETUP: begin
                    state    <= S_ACCESS;
                    p_enable <= 1'b1;
                    wait_cnt <= 8'd0;
                end
                S_ACCESS: begin
                    // A late p_ready on the final wait cycle still wins over the timeout.
                    if (p_ready) begin
                        p_sel    <= 1'b0;
                        p_enable <= 1'b0;
                        if (p_slverr) begin
                            state  <= S_ERR1;
                            h_resp <= 1'b1;
                        end else begin
                            state       <= S_IDLE;
                            h_ready_out <= 1'b1;
                            if (!p_write) begin
                                h_rdata <= p_rdata;
                            end
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= S_ERR1;
                        p_sel    <= 1'b0;
                        p_enable <= 1'b0;
                        h_resp   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    h_ready_out <= 1'b1;
                    h_resp      <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    h_ready_out <= 1'b1;
                    h_resp      <= 1'b0;
                    p_sel       <= 1'b0;
                    p_enable    <= 1'b0;
                end
            endcase
        end
    end

endmodule
